si570_i2c_target: RTL

I2C target (responder) that emulates the Si570 register interface for on-chip loopback and bench use. It decodes START/STOP, matches a 7-bit device address, and maintains an auto-incrementing register pointer. It issues single-cycle read/write strobes to an external 8-bit register port, so the `si570_ctrl` initiator can run against it without the physical oscillator.

---
 rtl/si570_i2c_target.sv | 127 ++++++++++++
 1 files changed

// File: rtl/si570_i2c_target.sv
// si570_i2c_target: Si570-style I2C register target; define SI570_I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample SCL/SDA glitch filter
module si570_i2c_target #(
   parameter logic [6:0] DEVICE_ADDR = 7'h55
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);
   typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RFETCH, RDATA, RACK, IGNORE} state_t;
   state_t state, state_d;
   logic [1:0] scl_r, sda_r;
   logic       scl_f, sda_f, scl_d, sda_d;
   logic [2:0] bit_cnt;
   logic [7:0] shreg, ptr, rx_byte;
   logic       scl_rise, scl_fall, start, stop, last, ack_st, shift_st, oe_d, we_set, re_set;
   // two-flop synchronizers; the bus idles high
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         scl_r <= 2'b11;
         sda_r <= 2'b11;
      end else begin
         scl_r <= {scl_r[0], scl_i};
         sda_r <= {sda_r[0], sda_i};
      end
`ifdef SI570_I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] scl_h, sda_h;
   // a line level is accepted only after three equal consecutive samples
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         scl_h <= 2'b11;
         sda_h <= 2'b11;
         scl_f <= 1'b1;
         sda_f <= 1'b1;
      end else begin
         scl_h <= {scl_h[0], scl_r[1]};
         sda_h <= {sda_h[0], sda_r[1]};
         scl_f <= (scl_r[1] == scl_h[0] && scl_h[0] == scl_h[1]) ? scl_r[1] : scl_f;
         sda_f <= (sda_r[1] == sda_h[0] && sda_h[0] == sda_h[1]) ? sda_r[1] : sda_f;
      end
`else
   assign scl_f = scl_r[1];
   assign sda_f = sda_r[1];
`endif
   // previous conditioned levels for edge detection
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   assign scl_rise = scl_f & ~scl_d;
   assign scl_fall = ~scl_f & scl_d;
   assign start    = scl_f & scl_d & sda_d & ~sda_f;
   assign stop     = scl_f & scl_d & ~sda_d & sda_f;
   assign rx_byte  = {shreg[6:0], sda_f};
   assign last     = scl_rise && bit_cnt == 3'd7;
   assign ack_st   = state inside {ADDR_ACK, PTR_ACK, WDATA_ACK};
   assign shift_st = state inside {ADDR, PTR, WDATA, RDATA};
   assign we_set   = state == WDATA && state_d == WDATA_ACK;
   assign re_set   = state == RFETCH && state_d == RFETCH && !reg_re;
   // next state and next SDA drive; ACK phases use sda_oe itself to tell drive from release
   always_comb begin
      state_d = state;
      oe_d    = 1'b0;
      if (start)
         state_d = ADDR;
      else if (stop)
         state_d = IDLE;
      else
         case (state)
            ADDR:      state_d = last ? (rx_byte[7:1] == DEVICE_ADDR ? ADDR_ACK : IGNORE) : ADDR;
            ADDR_ACK:  state_d = (scl_fall && sda_oe) ? (shreg[0] ? RFETCH : PTR) : ADDR_ACK;
            PTR:       state_d = last ? PTR_ACK : PTR;
            PTR_ACK:   state_d = (scl_fall && sda_oe) ? WDATA : PTR_ACK;
            WDATA:     state_d = last ? WDATA_ACK : WDATA;
            WDATA_ACK: state_d = (scl_fall && sda_oe) ? WDATA : WDATA_ACK;
            RFETCH:    state_d = reg_re ? RDATA : RFETCH;
            RDATA:     state_d = last ? RACK : RDATA;
            RACK:      state_d = scl_rise ? (sda_f ? IGNORE : RFETCH) : RACK;
            default:   state_d = state;
         endcase
      if (!(start || stop))
         oe_d = ack_st           ? sda_oe ^ scl_fall :
                state == RFETCH  ? ((reg_re && !scl_f) ? ~reg_rdata[7] : sda_oe) :
                state == RDATA   ? (scl_fall ? ~shreg[7] : sda_oe) :
                state == RACK    ? sda_oe & ~scl_fall : 1'b0;
   end
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_d;
   // bit counter, shift register, pointer, register strobes and bus outputs
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         ptr       <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         bit_cnt   <= (start || state_d != state) ? 3'd0 : (scl_rise && shift_st) ? bit_cnt + 3'd1 : bit_cnt;
         shreg     <= reg_re ? reg_rdata : (scl_rise && shift_st) ? rx_byte : shreg;
         ptr       <= (reg_we || reg_re) ? ptr + 8'd1 : (state == PTR && state_d == PTR_ACK) ? rx_byte : ptr;
         reg_we    <= we_set;
         reg_re    <= re_set;
         reg_addr  <= (we_set || re_set) ? ptr : reg_addr;
         reg_wdata <= we_set ? rx_byte : reg_wdata;
         sda_oe    <= oe_d;
         busy      <= state == ADDR_ACK ? 1'b1 : (state_d == IDLE || state_d == IGNORE) ? 1'b0 : busy;
      end
endmodule
